// File: rtl/inference_sequencer.sv
// Top-level controller for the ECG transformer datapath: captures one sample window,
// then steps embed/attention/MLP/reduce stages with start pulses, a watchdog and a held result.
module inference_sequencer #(
    parameter int N_SAMPLES = 15,
    parameter int DW        = 8,
    parameter int TO_W      = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic signed [DW-1:0]      in_data,
    output logic                      in_ready,
    output logic [N_SAMPLES*DW-1:0]   samples_o,
    output logic [3:0]                stage_start,
    input  logic [3:0]                stage_done,
    input  logic [3:0]                cls_in,
    output logic [3:0]                class_out,
    output logic                      class_valid,
    input  logic                      class_ready,
    output logic                      busy,
    output logic                      error,
    output logic [1:0]                err_stage,
    output logic [2:0]                dbg_state_o
);

    // Handshakes: a sample moves when in_valid & in_ready in the same cycle; the result
    // is taken when class_valid & class_ready; class_out stays stable while class_valid is high.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EMBED  = 3'd2,
        S_ATTN   = 3'd3,
        S_MLP    = 3'd4,
        S_RED    = 3'd5,
        S_RESULT = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(N_SAMPLES - 1);
    localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT);

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [TO_W-1:0]           wd_q, wd_d;
    logic [N_SAMPLES*DW-1:0]   samples_q, samples_d;
    logic [3:0]                class_q, class_d;
    logic [1:0]                err_q, err_d;

    logic [2:0]                st_bits;
    logic [2:0]                stage_off;
    logic [1:0]                stage_idx;
    logic                      done_k;

    // Stage states are contiguous, so the stage index is the offset from EMBED and
    // the successor of each stage (including RED -> RESULT) is simply state + 1.
    assign st_bits   = state_q;
    assign stage_off = st_bits - 3'(S_EMBED);
    assign stage_idx = stage_off[1:0];
    assign done_k    = stage_done[stage_idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        samples_d   = samples_q;
        class_d     = class_q;
        err_d       = err_q;
        stage_start = 4'b0000;
        in_ready    = 1'b0;
        busy        = 1'b0;
        error       = 1'b0;
        class_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    samples_d[cnt_q*DW +: DW] = in_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_EMBED;
                        wd_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_EMBED, S_ATTN, S_MLP, S_RED: begin
                busy = 1'b1;
                stage_start[stage_idx] = (wd_q == '0);
                wd_d = wd_q + 1'b1;
                // Done in the pulse cycle is ignored; done on the last watchdog cycle beats the timeout.
                if ((wd_q != '0) && done_k) begin
                    state_d = state_t'(st_bits + 3'd1);
                    wd_d    = '0;
                    if (state_q == S_RED) begin
                        class_d = cls_in;
                    end
                end else if (wd_q == TO_LIM) begin
                    state_d = S_ERROR;
                    err_d   = stage_idx;
                end
            end

            S_RESULT: begin
                class_valid = 1'b1;
                if (class_ready) begin
                    state_d = start ? S_LOAD : S_IDLE;
                    cnt_d   = '0;
                end
            end

            S_ERROR: begin
                error = 1'b1;
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    err_d   = 2'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            samples_q <= '0;
            class_q   <= 4'd0;
            err_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            samples_q <= samples_d;
            class_q   <= class_d;
            err_q     <= err_d;
        end
    end

    assign samples_o   = samples_q;
    assign class_out   = class_q;
    assign err_stage   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: full run, backpressure, spurious done,
// result hold, reset mid-stage and watchdog timeout with hand-computed expectations.
module tb_inference_sequencer;

    localparam int N  = 15;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [N*DW-1:0] samples_o;
    logic [3:0]      stage_start;
    logic [3:0]      stage_done;
    logic [3:0]      cls_in;
    logic [3:0]      class_out;
    logic            class_valid;
    logic            class_ready;
    logic            busy;
    logic            error;
    logic [1:0]      err_stage;
    logic [2:0]      dbg_state;

    int n_checks;
    int n_errors;
    logic [N*DW-1:0] exp_s;

    inference_sequencer #(
        .N_SAMPLES(N), .DW(DW), .TO_W(16), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .samples_o(samples_o), .stage_start(stage_start), .stage_done(stage_done),
        .cls_in(cls_in), .class_out(class_out), .class_valid(class_valid),
        .class_ready(class_ready), .busy(busy), .error(error),
        .err_stage(err_stage), .dbg_state_o(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_window(input int base, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'h55;
                tick();
            end
            in_valid = 1'b1;
            in_data  = 8'(base + k);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Entered on the pulse cycle of stage k; asserts done d cycles later.
    task automatic run_stage(input int k, input int d);
        check($sformatf("pulse%0d", k), stage_start, 4'b0001 << k);
        for (int i = 1; i <= d; i++) begin
            tick();
            check($sformatf("pulse_width%0d", k), stage_start, 4'b0000);
        end
        stage_done = 4'b0001 << k;
        tick();
        stage_done = 4'b0000;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        stage_done  = 4'b0000;
        cls_in      = 4'd0;
        class_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_samples", samples_o, '0);
        check("rst_pulses", stage_start, 4'b0000);
        check("rst_class_valid", class_valid, 1'b0);
        check("rst_error", error, 1'b0);

        // full run, samples -7..7
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_in_ready", in_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        load_window(-7, 1'b0);
        check("embed_in_ready", in_ready, 1'b0);
        for (int k = 0; k < N; k++) exp_s[k*DW +: DW] = 8'(k - 7);
        check("samples_full", samples_o, exp_s);
        cls_in = 4'd3;
        run_stage(0, 3);
        run_stage(1, 5);
        run_stage(2, 4);
        run_stage(3, 2);
        check("run_class_valid", class_valid, 1'b1);
        check("run_class_out", class_out, 4'd3);
        check("run_busy", busy, 1'b0);

        // result hold: start ignored while class_ready is low
        cls_in = 4'd9;
        start  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", class_valid, 1'b1);
            check("hold_class", class_out, 4'd3);
            check("hold_in_ready", in_ready, 1'b0);
        end
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        start       = 1'b0;
        check("hold_to_load", in_ready, 1'b1);
        check("hold_valid_drop", class_valid, 1'b0);

        // backpressure: 1..15 with bubbles
        load_window(1, 1'b1);
        check("bp_in_ready", in_ready, 1'b0);
        for (int k = 0; k < N; k++) exp_s[k*DW +: DW] = 8'(k + 1);
        check("bp_samples", samples_o, exp_s);

        // spurious done: done[0] in the pulse cycle, done[2] during EMBED, plus a 16th sample
        check("sp_pulse", stage_start, 4'b0001);
        stage_done = 4'b0001;
        in_valid   = 1'b1;
        in_data    = 8'd99;
        tick();
        check("sp_no_adv_a", stage_start, 4'b0000);
        check("sp_busy", busy, 1'b1);
        stage_done = 4'b0100;
        in_valid   = 1'b0;
        tick();
        check("sp_no_adv_b", stage_start, 4'b0000);
        stage_done = 4'b0000;
        tick();
        check("sp_no_adv_c", stage_start, 4'b0000);
        check("bp_16th_ignored", samples_o, exp_s);
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0000;
        check("sp_adv_attn", stage_start, 4'b0010);

        // reset mid-ATTN
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", busy, 1'b0);
        check("mrst_pulses", stage_start, 4'b0000);
        check("mrst_class_valid", class_valid, 1'b0);
        check("mrst_samples", samples_o, '0);
        check("mrst_in_ready", in_ready, 1'b0);
        check("mrst_class_out", class_out, 4'd0);

        // fresh start, attn never done -> timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_load", in_ready, 1'b1);
        load_window(20, 1'b0);
        run_stage(0, 3);
        check("to_attn_pulse", stage_start, 4'b0010);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("to_error_c%0d", i), error, (i == 9));
        end
        check("to_err_stage", err_stage, 2'd1);
        check("to_busy", busy, 1'b0);
        tick();
        check("to_err_hold", error, 1'b1);
        check("to_no_pulse", stage_start, 4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_clear_err", error, 1'b0);
        check("to_clear_stage", err_stage, 2'd0);
        check("to_restart", in_ready, 1'b1);

        // run with done exactly on the timeout cycle and minimum delays
        load_window(-3, 1'b0);
        cls_in = 4'hA;
        run_stage(0, 8);
        run_stage(1, 1);
        run_stage(2, 2);
        run_stage(3, 1);
        check("edge_no_error", error, 1'b0);
        check("edge_class_valid", class_valid, 1'b1);
        check("edge_class_out", class_out, 4'hA);
        cls_in      = 4'h1;
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        check("idle_valid", class_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_class_persist", class_out, 4'hA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
